composite_line_scheduler: RTL and testbench



---
 rtl/video_pkg.sv | 22 ++
 rtl/composite_pixel_addr_gen.sv | 44 ++++
 rtl/composite_line_scheduler.sv | 135 +++++++++++++
 tb/tb_composite_line_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video timing definitions: default raster geometry and the line
// scheduler's FSM encoding, common to the timing generator and renderer.
package video_pkg;

    localparam int VID_H_PIXELS     = 640;
    localparam int VID_V_LINES      = 240;
    localparam int VID_CLKS_PER_PIX = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RENDERING = 2'd1;
    localparam state_t ST_READY     = 2'd2;

    // Source line number: interlaced fields interleave as 2n + field.
    function automatic logic [15:0] field_line(input logic [15:0] n,
                                               input logic field,
                                               input logic interlace);
        return interlace ? {n[14:0], field} : n;
    endfunction

endpackage

// File: rtl/composite_pixel_addr_gen.sv
// Pixel read address generator: clock divider plus a saturating address
// counter, cleared at the start of every line.
module composite_pixel_addr_gen #(
    parameter int H_PIXELS     = 640,
    parameter int CLKS_PER_PIX = 2,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_line,
    input  logic              next_pixel,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int DIV_W = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_PIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_PIXELS - 1);

    logic [DIV_W-1:0]  div_reg;
    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            addr_reg <= '0;
        end else if (next_line) begin
            div_reg  <= '0;
            addr_reg <= '0;
        end else if (next_pixel) begin
            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                // Hold on the last pixel if the active region overruns.
                if (addr_reg != ADDR_LAST) begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

    assign rd_addr = addr_reg;

endmodule

// File: rtl/composite_line_scheduler.sv
// Per-line render sequencer: prefetches a line at vblank, swaps the ping-pong
// line buffers on every line strobe and flags renderers that finish late.
module composite_line_scheduler
    import video_pkg::*;
#(
    parameter int H_PIXELS     = VID_H_PIXELS,
    parameter int V_LINES      = VID_V_LINES,
    parameter int CLKS_PER_PIX = VID_CLKS_PER_PIX,
    parameter int ADDR_W       = 10,
    parameter int LINE_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_frame,
    input  logic              next_line,
    input  logic              next_pixel,
    input  logic              vblank_pulse,
    input  logic              current_field,
    input  logic              interlace,
    output logic              render_start,
    output logic [LINE_W-1:0] render_line,
    output logic              render_buf,
    input  logic              render_done,
    output logic              rd_buf,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic              busy
);

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);

    state_t            state_reg, state_next;
    logic [LINE_W-1:0] n_reg, n_next;
    logic [LINE_W-1:0] render_line_reg, render_line_next;
    logic              field_reg, field_next;
    logic              render_start_reg, render_start_next;
    logic              render_buf_reg, render_buf_next;
    logic              rd_buf_reg, rd_buf_next;
    logic              underrun_reg, underrun_next;
    logic              swapped_reg, swapped_next;
    logic              late;

    always_comb begin
        state_next        = state_reg;
        n_next            = n_reg;
        render_line_next  = render_line_reg;
        field_next        = field_reg;
        render_start_next = 1'b0;
        render_buf_next   = render_buf_reg;
        rd_buf_next       = rd_buf_reg;
        swapped_next      = swapped_reg;
        late              = 1'b0;

        if (vblank_pulse) begin
            // Prefetch line 0 of the coming field; overrides a coincident line strobe.
            field_next        = interlace ? ~field_reg : 1'b0;
            n_next            = '0;
            render_buf_next   = 1'b0;
            render_start_next = 1'b1;
            render_line_next  = LINE_W'(field_line(16'd0, field_next, interlace));
            state_next        = ST_RENDERING;
            swapped_next      = 1'b0;
        end else begin
            if (next_frame) begin
                field_next = current_field;
            end
            if (next_line && state_reg != ST_IDLE) begin
                late            = (state_reg == ST_RENDERING) && !render_done;
                rd_buf_next     = render_buf_reg;
                render_buf_next = ~render_buf_reg;
                n_next          = n_reg + 1'b1;
                swapped_next    = 1'b1;
                if (n_reg < LAST_LINE) begin
                    render_start_next = 1'b1;
                    render_line_next  = LINE_W'(field_line(16'(n_next), field_next, interlace));
                    state_next        = ST_RENDERING;
                end else begin
                    state_next = ST_IDLE;
                end
            end else if (render_done && state_reg == ST_RENDERING) begin
                state_next = ST_READY;
            end
        end

        underrun_next = late | (underrun_reg & ~underrun_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            n_reg            <= '0;
            render_line_reg  <= '0;
            field_reg        <= 1'b0;
            render_start_reg <= 1'b0;
            render_buf_reg   <= 1'b0;
            rd_buf_reg       <= 1'b0;
            underrun_reg     <= 1'b0;
            swapped_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            n_reg            <= n_next;
            render_line_reg  <= render_line_next;
            field_reg        <= field_next;
            render_start_reg <= render_start_next;
            render_buf_reg   <= render_buf_next;
            rd_buf_reg       <= rd_buf_next;
            underrun_reg     <= underrun_next;
            swapped_reg      <= swapped_next;
        end
    end

    composite_pixel_addr_gen #(
        .H_PIXELS    (H_PIXELS),
        .CLKS_PER_PIX(CLKS_PER_PIX),
        .ADDR_W      (ADDR_W)
    ) u_pixel_addr (
        .clk       (clk),
        .rst       (rst),
        .next_line (next_line),
        .next_pixel(next_pixel),
        .rd_addr   (rd_addr)
    );

    assign render_start = render_start_reg;
    assign render_line  = render_line_reg;
    assign render_buf   = render_buf_reg;
    assign rd_buf       = rd_buf_reg;
    assign underrun     = underrun_reg;
    assign busy         = (state_reg != ST_IDLE);
    // Pixels are only meaningful once a rendered line has been swapped in this field.
    assign rd_valid     = next_pixel & swapped_reg;

endmodule

// File: tb/tb_composite_line_scheduler.sv
// Directed/randomized bench for composite_line_scheduler against a
// line-level behavioural model of the scheduling rules.
module tb_composite_line_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       next_frame, next_line, next_pixel, vblank_pulse;
    logic       current_field, interlace, render_done, underrun_clr;
    logic       render_start, render_buf, rd_buf, rd_valid, underrun, busy;
    logic [8:0] render_line;
    logic [9:0] rd_addr;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Line-level model state.
    bit field_m, underrun_m, idle_m, rendering_m, swapped_m;
    bit rd_buf_m, rbuf_m, il_m;
    int n_m;

    always #5 clk = ~clk;

    composite_line_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .next_frame   (next_frame),
        .next_line    (next_line),
        .next_pixel   (next_pixel),
        .vblank_pulse (vblank_pulse),
        .current_field(current_field),
        .interlace    (interlace),
        .render_start (render_start),
        .render_line  (render_line),
        .render_buf   (render_buf),
        .render_done  (render_done),
        .rd_buf       (rd_buf),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_line(input int k);
        return il_m ? (2 * k + int'(field_m)) : k;
    endfunction

    task automatic vblank_step(input bit il, input bit with_line);
        interlace    = il;
        vblank_pulse = 1'b1;
        next_line    = with_line;
        tick();
        vblank_pulse = 1'b0;
        next_line    = 1'b0;
        il_m        = il;
        field_m     = il ? ~field_m : 1'b0;
        n_m         = 0;
        rbuf_m      = 1'b0;
        idle_m      = 1'b0;
        rendering_m = 1'b1;
        swapped_m   = 1'b0;
        check("vb_start", render_start, 1);
        check("vb_line", render_line, exp_line(0));
        check("vb_buf", render_buf, 0);
        check("vb_busy", busy, 1);
        check("vb_underrun", underrun, underrun_m);
        $display("vblank il=%0d line=%0d buf=%0d", il, render_line, render_buf);
    endtask

    // One display line: renderer activity during the line, then the line strobe.
    task automatic line_step(input bit give_done, input bit coincident, input bit is_frame,
                             input bit cf, input bit clr, input bit pix_run);
        int  gap, done_at, exp_addr;
        bit  late, started;
        gap     = pix_run ? 1300 : int'($urandom_range(8, 30));
        done_at = (give_done && !coincident) ? int'($urandom_range(2, pix_run ? 60 : gap - 3)) : -1;
        for (int i = 0; i < gap; i++) begin
            next_pixel  = (i >= 1);
            render_done = (done_at >= 0) && (i == done_at || i == done_at + 2);
            #1;
            if (i == 1) begin
                check("start_pulse_end", render_start, 0);
                check("rd_valid", rd_valid, swapped_m);
            end
            if (pix_run && i >= 1) begin
                exp_addr = ((i - 1) / 2 > 639) ? 639 : (i - 1) / 2;
                check("pix_addr", rd_addr, exp_addr);
            end
            tick();
            if (i == done_at && !idle_m) rendering_m = 1'b0;
        end
        next_pixel    = 1'b0;
        render_done   = coincident;
        next_line     = 1'b1;
        next_frame    = is_frame;
        current_field = cf;
        underrun_clr  = clr;
        tick();
        render_done  = 1'b0;
        next_line    = 1'b0;
        next_frame   = 1'b0;
        underrun_clr = 1'b0;

        if (is_frame) field_m = cf;
        started = 1'b0;
        if (!idle_m) begin
            late       = rendering_m && !coincident;
            underrun_m = late | (underrun_m & !clr);
            rd_buf_m   = rbuf_m;
            rbuf_m     = !rbuf_m;
            n_m++;
            swapped_m  = 1'b1;
            if (n_m < 240) begin
                rendering_m = 1'b1;
                started     = 1'b1;
            end else begin
                idle_m = 1'b1;
            end
        end else begin
            underrun_m = underrun_m & !clr;
        end
        check("underrun", underrun, underrun_m);
        check("rd_buf", rd_buf, rd_buf_m);
        check("render_buf", render_buf, rbuf_m);
        check("busy", busy, !idle_m);
        check("render_start", render_start, started);
        if (started) check("render_line", render_line, exp_line(n_m));
        check("addr_clear", rd_addr, 0);
        $display("line n=%0d start=%0d rline=%0d rbuf=%0d rdbuf=%0d underrun=%0d",
                 n_m, render_start, render_line, render_buf, rd_buf, underrun);
    endtask

    task automatic run_field(input bit il, input bit cf, input int late_k, input int pix_k);
        bit coinc;
        vblank_step(il, 1'b0);
        for (int k = 0; k < 240; k++) begin
            coinc = ($urandom_range(0, 7) == 0) && (k != late_k);
            line_step(k != late_k, coinc, k == 0, cf, 1'b0, k == pix_k);
        end
        check("field_end_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        next_frame = 1'b0; next_line = 1'b0; next_pixel = 1'b0; vblank_pulse = 1'b0;
        current_field = 1'b0; interlace = 1'b0; render_done = 1'b0; underrun_clr = 1'b0;
        field_m = 0; underrun_m = 0; idle_m = 1; rendering_m = 0; swapped_m = 0;
        rd_buf_m = 0; rbuf_m = 0; il_m = 0; n_m = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_start", render_start, 0);
        check("rst_line", render_line, 0);
        check("rst_rbuf", render_buf, 0);
        check("rst_rdbuf", rd_buf, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);
        next_pixel = 1'b1;
        #1;
        check("rst_valid", rd_valid, 0);
        next_pixel = 1'b0;

        // Line strobes while idle are ignored.
        line_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Progressive field with a long pixel run on line 10, then 480i fields 1 and 0.
        run_field(1'b0, 1'b0, -1, 10);
        line_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_field(1'b1, 1'b1, -1, -1);
        run_field(1'b1, 1'b0, -1, -1);

        // Late renderer on line 5, clear, then set and clear together.
        vblank_step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) line_step(1'b1, 1'b0, k == 0, 1'b0, 1'b0, 1'b0);
        line_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        line_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        underrun_m   = 1'b0;
        check("clr_only", underrun, underrun_m);
        line_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // vblank coincident with next_line while still rendering: vblank wins.
        repeat (4) tick();
        vblank_step(1'b0, 1'b1);

        // Interlaced field whose first next_frame disagrees with the toggled field.
        vblank_step(1'b1, 1'b0);
        line_step(1'b1, 1'b0, 1'b1, ~field_m, 1'b0, 1'b0);
        line_step(1'b1, 1'b0, 1'b0, field_m, 1'b0, 1'b0);
        line_step(1'b1, 1'b0, 1'b0, field_m, 1'b0, 1'b0);

        // Asynchronous reset between edges while rendering.
        next_pixel = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_start", render_start, 0);
        check("arst_line", render_line, 0);
        check("arst_rbuf", render_buf, 0);
        check("arst_rdbuf", rd_buf, 0);
        check("arst_addr", rd_addr, 0);
        check("arst_valid", rd_valid, 0);
        check("arst_underrun", underrun, 0);
        check("arst_busy", busy, 0);
        next_pixel = 1'b0;
        tick();
        rst = 1'b0;
        field_m = 0; underrun_m = 0; idle_m = 1; rendering_m = 0; swapped_m = 0;
        rd_buf_m = 0; rbuf_m = 0; n_m = 0;
        line_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        line_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vblank_step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) line_step(1'b1, k == 2, k == 0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
